popcount_pipe: RTL and testbench
================================

Name: popcount_pipe

Overview:
- Parametrised, pipelined population counter; successor to the combinational 7-bit ones-counter.
- Counts set bits of a W-bit word per beat and carries a running per-packet accumulation.
- Valid/ready streaming handshake on both sides, two-stage registered pipeline with full backpressure.
- Sits between a bit-vector producer, such as a flag or mask source, and a consumer needing per-beat and per-packet counts.

Parameters:
- W, 7, input word width (1..64).
- CHUNK, 4, bits per stage-1 partial adder (1..W).
- ACC_W, 8, accumulator width.
- Derived, not overridable: CW = $clog2(W+1); NCH = ceil(W/CHUNK).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  input beat valid
- in_data  input  W  word to count
- in_last  input  1  final beat of packet
- in_ready  output  1  input accepted when in_valid && in_ready
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts when out_valid && out_ready
- out_count  output  CW  ones in the beat's in_data
- out_acc  output  ACC_W  running packet sum including this beat
- out_last  output  1  beat was packet's last

Behaviour:
- Reset (async, active-high): s1_valid=0, out_valid=0, out_count=0, out_acc=0, out_last=0, acc_base=0. No beat survives reset; a packet in flight is discarded and the next accepted beat starts a fresh packet.
- advance = !out_valid || out_ready. in_ready = advance. in_ready is combinational from out_valid/out_ready only, never from in_valid.
- Stage 1 (on advance):
  - s1_valid <= in_valid.
  - If in_valid: s1_part[k] <= popcount(in_data[k*CHUNK +: CHUNK]) for k = 0..NCH-1; the last chunk is zero-padded above W.
  - s1_last <= in_last.
  - If !in_valid, the s1 data registers hold their value (don't-care).
- Stage 2 (on advance):
  - out_valid <= s1_valid.
  - If s1_valid:
    - cnt = sum of s1_part, CW bits.
    - out_count <= cnt; out_last <= s1_last.
    - out_acc <= acc_base + cnt.
    - acc_base <= s1_last ? 0 : acc_base + cnt.
  - If !s1_valid, data outputs hold.
- When !advance, every register holds and outputs are stable. out_valid never drops without a handshake.
- Latency: 2 cycles from input handshake to out_valid with no stall. Throughput: 1 beat/cycle when out_ready is held high.
- Accumulator arithmetic is modulo 2^ACC_W, wrapping, unless the optional feature is enabled.
- A single-beat packet (in_last on its first beat) gives out_acc = out_count.
- Bubbles (in_valid=0) pass through without touching acc_base.
- in_data=0 gives out_count=0; all-ones gives out_count=W.
- Simultaneous stall and new input: the input is not accepted and in_data must be held by the producer.
- in_last is only meaningful when in_valid=1.

Optional Feature:
- Macro: POPCOUNT_ACC_SAT_EN.
- Defined: the out_acc and acc_base sums saturate at 2^ACC_W-1 instead of wrapping. An extra output acc_sat (1 bit, reset 0) is set with out_acc on any beat whose unclamped sum overflowed, and is sticky through the rest of that packet. acc_base clears at in_last as usual.
- Undefined: modulo wrap, and the acc_sat port does not exist.

Test Plan:
- Reset then single beat: in_data=7'b1011001, in_last=1, out_ready=1. Two cycles later: out_valid=1, out_count=4, out_acc=4, out_last=1.
- Packet of 3 beats: 7'h7F, 7'h00, 7'h15 with last on beat 3. Expect out_count 7,0,3; out_acc 7,7,10; out_last on beat 3 only. A following single beat 7'h01 gives out_acc=1.
- Backpressure: stream 5 beats with out_ready low for 3 cycles mid-stream. Expect in_ready=0 while out_valid && !out_ready, outputs stable, no beat lost or duplicated, and order preserved.
- Wrap, W=7, ACC_W=4: three beats of 7'h7F, last on beat 3. Expect out_acc 7, 14, 5 (21 mod 16). With POPCOUNT_ACC_SAT_EN: 7, 14, 15 and acc_sat=1 on beat 3.
- Async reset mid-packet: assert reset between beats 1 and 2 with s1_valid=1. Expect out_valid=0 immediately without waiting for a clock edge. After release, beat 7'h03 with last gives out_acc=2.
- Parametric, W=16, CHUNK=5: in_data=16'hFFFF gives out_count=16 (CW=5). in_data=16'h8001 gives 2.

Source files
------------

// File: rtl/popcount_pipe.sv
// popcount_pipe: two-stage pipelined population counter with a running
// per-packet accumulator and a valid/ready handshake on both sides.
// Stage 1 latches per-chunk partial counts and stage 2 sums them and updates
// the accumulator.
// Optional macro POPCOUNT_ACC_SAT_EN: the accumulator saturates instead of
// wrapping, and an acc_sat flag output is added.

// Counts the ones in one CHUNK-wide slice of the input word.
module popcount_chunk #(
    parameter int CHUNK = 4,
    parameter int PW    = 3
) (
    input  logic [CHUNK-1:0] d,
    output logic [PW-1:0]    cnt
);
    // Ripple-add each bit of the slice.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) cnt = cnt + PW'(d[i]);
    end
endmodule

module popcount_pipe #(
    parameter  int W     = 7,
    parameter  int CHUNK = 4,
    parameter  int ACC_W = 8,
    localparam int CW    = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CW-1:0]    out_count,
    output logic [ACC_W-1:0] out_acc,
    output logic             out_last
`ifdef POPCOUNT_ACC_SAT_EN
   ,output logic             acc_sat
`endif
);
    localparam int NCH  = (W + CHUNK - 1) / CHUNK;
    localparam int PW   = $clog2(CHUNK + 1);
    localparam int PADW = NCH * CHUNK;

    logic                     advance;
    logic [2:1]               vld_pipe;   // [1] = stage-1 valid, [2] = output valid
    logic [PADW-1:0]          din_pad;
    logic [NCH-1:0][PW-1:0]   part_d;
    logic [NCH-1:0][PW-1:0]   s1_part;
    logic                     s1_last;
    logic [CW-1:0]            cnt;
    logic [ACC_W-1:0]         acc_base;
    logic [ACC_W-1:0]         acc_next;

    // The whole pipe moves as one: it can advance whenever the output slot
    // is empty or being drained, so in_ready never depends on in_valid.
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign out_valid = vld_pipe[2];

    // The final chunk reads zeros above W.
    assign din_pad = PADW'(in_data);

    for (genvar k = 0; k < NCH; k++) begin : g_chunk
        popcount_chunk #(.CHUNK(CHUNK), .PW(PW)) u_chunk (
            .d   (din_pad[k*CHUNK +: CHUNK]),
            .cnt (part_d[k])
        );
    end

    // Stage 2 adder tree: fold the partial counts into the beat total.
    always_comb begin
        cnt = '0;
        for (int k = 0; k < NCH; k++) cnt = cnt + CW'(s1_part[k]);
    end

`ifdef POPCOUNT_ACC_SAT_EN
    localparam int SW = ((ACC_W > CW) ? ACC_W : CW) + 1;
    logic [SW-1:0] sum;
    logic          ovf;
    logic          sat_base;

    // Widened sum so an overflow can be detected and clamped.
    always_comb begin
        sum      = SW'(acc_base) + SW'(cnt);
        ovf      = |sum[SW-1:ACC_W];
        acc_next = ovf ? '1 : sum[ACC_W-1:0];
    end

    // Overflow flag stays set for the rest of the packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_sat  <= 1'b0;
            sat_base <= 1'b0;
        end else if (advance && vld_pipe[1]) begin
            acc_sat  <= sat_base | ovf;
            sat_base <= s1_last ? 1'b0 : (sat_base | ovf);
        end
    end
`else
    // Modulo-2^ACC_W accumulation.
    always_comb begin
        acc_next = acc_base + ACC_W'(cnt);
    end
`endif

    // Valid shift register; bubbles travel through it like beats.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) vld_pipe <= '0;
        else if (advance) vld_pipe <= {vld_pipe[1], in_valid};
    end

    // Stage 1 data: partial counts only load on a real beat.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_part <= '0;
            s1_last <= 1'b0;
        end else if (advance && in_valid) begin
            s1_part <= part_d;
            s1_last <= in_last;
        end
    end

    // Stage 2 data: beat result and running packet sum; the sum restarts
    // after the last beat of a packet.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_count <= '0;
            out_acc   <= '0;
            out_last  <= 1'b0;
            acc_base  <= '0;
        end else if (advance && vld_pipe[1]) begin
            out_count <= cnt;
            out_acc   <= acc_next;
            out_last  <= s1_last;
            acc_base  <= s1_last ? '0 : acc_next;
        end
    end
endmodule

// File: tb/tb_popcount_pipe.sv
// Directed bench for popcount_pipe: table-driven beats on a default instance,
// plus hand sequences for backpressure, async reset, wrap and wide words.
module tb_popcount_pipe;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default instance: W=7, CHUNK=4, ACC_W=8
    logic       in_valid, in_last, in_ready, out_valid, out_ready, out_last;
    logic [6:0] in_data;
    logic [2:0] out_count;
    logic [7:0] out_acc;
    // wrap instance: W=7, ACC_W=4
    logic       w_in_valid, w_in_last, w_in_ready, w_out_valid, w_out_ready, w_out_last;
    logic [6:0] w_in_data;
    logic [2:0] w_out_count;
    logic [3:0] w_out_acc;
    // wide instance: W=16, CHUNK=5
    logic        p_in_valid, p_in_last, p_in_ready, p_out_valid, p_out_ready, p_out_last;
    logic [15:0] p_in_data;
    logic [4:0]  p_out_count;
    logic [7:0]  p_out_acc;
`ifdef POPCOUNT_ACC_SAT_EN
    logic acc_sat, w_acc_sat, p_acc_sat;
`endif

    popcount_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_count(out_count), .out_acc(out_acc),
        .out_last(out_last)
`ifdef POPCOUNT_ACC_SAT_EN
       ,.acc_sat(acc_sat)
`endif
    );

    popcount_pipe #(.W(7), .CHUNK(4), .ACC_W(4)) dut_w (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .in_data(w_in_data),
        .in_last(w_in_last), .in_ready(w_in_ready), .out_valid(w_out_valid),
        .out_ready(w_out_ready), .out_count(w_out_count), .out_acc(w_out_acc),
        .out_last(w_out_last)
`ifdef POPCOUNT_ACC_SAT_EN
       ,.acc_sat(w_acc_sat)
`endif
    );

    popcount_pipe #(.W(16), .CHUNK(5), .ACC_W(8)) dut_p (
        .clk(clk), .reset(reset), .in_valid(p_in_valid), .in_data(p_in_data),
        .in_last(p_in_last), .in_ready(p_in_ready), .out_valid(p_out_valid),
        .out_ready(p_out_ready), .out_count(p_out_count), .out_acc(p_out_acc),
        .out_last(p_out_last)
`ifdef POPCOUNT_ACC_SAT_EN
       ,.acc_sat(p_acc_sat)
`endif
    );

    typedef struct {
        int         gap;
        logic [6:0] d;
        logic       l;
        logic [2:0] c;
        logic [7:0] a;
        logic       el;
    } vec_t;

    typedef struct {
        logic [2:0] c;
        logic [7:0] a;
        logic       l;
    } exp_t;

    vec_t tbl[$];
    exp_t expq[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    task automatic push(input logic [6:0] d, input logic l);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_last = l;
        @(negedge clk);
        while (!in_ready && n < 50) begin n++; @(negedge clk); end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL push_timeout: in_ready stuck at 0 for data %0h", d);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (expq.size() != 0 && n < 40) begin @(negedge clk); n++; end
        if (expq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain: %0d beats missing, want 0", expq.size());
        end
        @(posedge clk); #1;
    endtask

    logic [3:0] wexp_acc[3];
    logic       wexp_sat[3];

    initial begin
        logic [11:0] held;
        logic        holding;
        reset = 1'b1;
        in_valid = 0; in_data = '0; in_last = 0; out_ready = 1;
        w_in_valid = 0; w_in_data = '0; w_in_last = 0; w_out_ready = 1;
        p_in_valid = 0; p_in_data = '0; p_in_last = 0; p_out_ready = 1;
        holding = 1'b0; held = '0;

        // vectors: gap, data, last, exp count, exp acc, exp last
        tbl.push_back('{0, 7'h59, 1'b1, 3'd4, 8'd4,  1'b1});
        tbl.push_back('{0, 7'h7F, 1'b0, 3'd7, 8'd7,  1'b0});
        tbl.push_back('{0, 7'h00, 1'b0, 3'd0, 8'd7,  1'b0});
        tbl.push_back('{0, 7'h15, 1'b1, 3'd3, 8'd10, 1'b1});
        tbl.push_back('{0, 7'h01, 1'b1, 3'd1, 8'd1,  1'b1});
        tbl.push_back('{1, 7'h7F, 1'b1, 3'd7, 8'd7,  1'b1});
        tbl.push_back('{0, 7'h00, 1'b1, 3'd0, 8'd0,  1'b1});
        tbl.push_back('{0, 7'h03, 1'b0, 3'd2, 8'd2,  1'b0});
        tbl.push_back('{2, 7'h40, 1'b1, 3'd1, 8'd3,  1'b1});

`ifdef POPCOUNT_ACC_SAT_EN
        wexp_acc = '{4'd7, 4'd14, 4'd15};
        wexp_sat = '{1'b0, 1'b0, 1'b1};
`else
        wexp_acc = '{4'd7, 4'd14, 4'd5};
        wexp_sat = '{1'b0, 1'b0, 1'b0};
`endif

        // output monitor for the default instance
        fork
            forever begin
                @(negedge clk);
                if (reset) holding = 1'b0;
                else begin
                    if (holding)
                        check("stall_stable", {out_valid, out_count, out_acc, out_last},
                              {1'b1, held});
                    if (out_valid && !out_ready) begin
                        check("stall_in_ready", in_ready, 1'b0);
                        holding = 1'b1;
                        held = {out_count, out_acc, out_last};
                    end else holding = 1'b0;
                    if (out_valid && out_ready) begin
                        if (expq.size() == 0) begin
                            total++; bad++;
                            $display("FAIL extra_beat: got count=%0d acc=%0d, want no beat",
                                     out_count, out_acc);
                        end else begin
                            exp_t e;
                            e = expq.pop_front();
                            check("beat", {out_count, out_acc, out_last}, {e.c, e.a, e.l});
                        end
                    end
                end
            end
        join_none

        // reset state
        @(posedge clk); #1;
        check("reset_out", {out_valid, out_count, out_acc, out_last}, 32'd0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_w", {w_out_valid, w_out_acc, p_out_valid, p_out_acc}, 32'd0);
        reset = 1'b0;
        idle(1);

        // table-driven beats with out_ready held high
        foreach (tbl[i]) begin
            idle(tbl[i].gap);
            expq.push_back('{tbl[i].c, tbl[i].a, tbl[i].el});
            push(tbl[i].d, tbl[i].l);
        end
        drain();

        // backpressure: 5-beat packet, out_ready low for 3 cycles mid-stream
        fork
            begin
                logic [6:0] bd [5];
                logic [7:0] ba [5];
                bd = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F};
                ba = '{8'd1, 8'd3, 8'd6, 8'd10, 8'd15};
                for (int i = 0; i < 5; i++) begin
                    expq.push_back('{3'(i + 1), ba[i], i == 4});
                    push(bd[i], i == 4);
                end
            end
            begin
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #2 out_ready = 1'b1;
            end
        join
        drain();

        // async reset with beats in both stages
        out_ready = 1'b0;
        push(7'h01, 1'b0);
        push(7'h02, 1'b0);
        check("pre_reset_valid", {out_valid, in_ready, out_count}, {1'b1, 1'b0, 3'd1});
        #2 reset = 1'b1;
        #1 check("async_reset", {out_valid, out_count, out_acc, out_last, in_ready},
                 {1'b0, 3'd0, 8'd0, 1'b0, 1'b1});
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        expq.push_back('{3'd2, 8'd2, 1'b1});
        push(7'h03, 1'b1);
        drain();

        // wrap / saturate on the 4-bit accumulator
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                w_in_valid = 1'b1; w_in_data = 7'h7F; w_in_last = (i == 2);
            end else w_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (i >= 1) begin
`ifdef POPCOUNT_ACC_SAT_EN
                check("wrap_sat", {w_out_valid, w_out_count, w_out_acc, w_out_last, w_acc_sat},
                      {1'b1, 3'd7, wexp_acc[i-1], i == 3, wexp_sat[i-1]});
`else
                check("wrap", {w_out_valid, w_out_count, w_out_acc, w_out_last},
                      {1'b1, 3'd7, wexp_acc[i-1], i == 3});
`endif
            end
        end
        w_in_valid = 1'b0;

        // wide word, CHUNK not dividing W
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                p_in_valid = 1'b1; p_in_data = (i == 0) ? 16'hFFFF : 16'h8001;
                p_in_last = (i == 1);
            end else p_in_valid = 1'b0;
            @(posedge clk);
            @(negedge clk);
            if (i == 1)
                check("wide_ffff", {p_out_valid, p_out_count, p_out_acc, p_out_last},
                      {1'b1, 5'd16, 8'd16, 1'b0});
            if (i == 2)
                check("wide_8001", {p_out_valid, p_out_count, p_out_acc, p_out_last},
                      {1'b1, 5'd2, 8'd18, 1'b1});
            if (i == 3)
                check("wide_idle", p_out_valid, 1'b0);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, want finish");
        $fatal(1);
    end
endmodule
